// File: rtl/skid_pipe_reg.sv
// Two-entry skid pipeline register: registered handshake outputs, full throughput,
// synchronous flush and asynchronous active-low reset.
module skid_pipe_reg #(
  parameter int unsigned       WIDTH      = 151,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // State encoding equals the number of held entries, so count is the state register.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer, out_xfer;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign count     = state_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Held entries and any coincident input are dropped; data registers keep their value.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d = StBusy;
            main_d  = in_data;
          end
        end
        StBusy: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_xfer) begin
            state_d = StBusy;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      main_q  <= RESET_DATA;
      skid_q  <= RESET_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Scoreboard bench for skid_pipe_reg: a wide (151-bit) and a 1-bit instance share the
// same handshake stimulus; a payload queue is the reference model of held entries.
module tb_skid_pipe_reg;

  localparam int W = 151;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_data;

  logic         in_ready_w, out_valid_w;
  logic [W-1:0] out_data_w;
  logic [1:0]   count_w;
  logic         in_ready_n, out_valid_n;
  logic [0:0]   out_data_n;
  logic [1:0]   count_n;

  logic [W-1:0] exp_q[$];
  int           vectors    = 0;
  int           miscompares = 0;
  bit           mon_en     = 1'b0;

  always #5 clk = ~clk;

  skid_pipe_reg #(
    .WIDTH(W)
  ) dut_w (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready_w),
    .in_data  (in_data),
    .out_valid(out_valid_w),
    .out_ready(out_ready),
    .out_data (out_data_w),
    .count    (count_w)
  );

  skid_pipe_reg #(
    .WIDTH     (1),
    .RESET_DATA(1'b1)
  ) dut_n (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready_n),
    .in_data  (in_data[0:0]),
    .out_valid(out_valid_n),
    .out_ready(out_ready),
    .out_data (out_data_n),
    .count    (count_n)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 5; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // Inputs change 1 time unit after the falling edge; an accepted payload joins the model.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    if (v && !f && exp_q.size() < 2) exp_q.push_back(d);
  endtask

  // Monitor: state check on the falling edge, transfer check after the inputs settle.
  initial begin : monitor
    int           sz;
    logic [W-1:0] h;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        sz = exp_q.size();
        chk("w_count", W'(count_w), W'(sz));
        chk("w_in_ready", W'(in_ready_w), W'(sz < 2));
        chk("w_out_valid", W'(out_valid_w), W'(sz > 0));
        chk("n_count", W'(count_n), W'(sz));
        chk("n_in_ready", W'(in_ready_n), W'(sz < 2));
        chk("n_out_valid", W'(out_valid_n), W'(sz > 0));
        chk("no_x", W'($isunknown({in_ready_w, out_valid_w, out_data_w, count_w,
                                   in_ready_n, out_valid_n, out_data_n, count_n})), '0);
        if (sz > 0) begin
          h = exp_q[0];
          chk("w_out_data", out_data_w, h);
          chk("n_out_data", W'(out_data_n), W'(h[0]));
        end
      end
      #2;
      if (mon_en) begin
        if (out_valid_w && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_output", W'(1), W'(0));
          end else begin
            h = exp_q.pop_front();
            chk("w_delivered", out_data_w, h);
            chk("n_delivered", W'(out_data_n), W'(h[0]));
          end
        end
        if (flush) exp_q.delete();
      end
    end
  end

  initial begin : stimulus
    logic [W-1:0] a, b;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_w_data", out_data_w, '0);
    chk("rst_n_data", W'(out_data_n), W'(1));
    chk("rst_count", W'(count_w), '0);
    chk("rst_in_ready", W'(in_ready_w), W'(1));
    chk("rst_out_valid", W'(out_valid_w), '0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Pass-through with out_ready high.
    drive(1'b1, W'(1), 1'b1, 1'b0);
    drive(1'b1, W'(2), 1'b1, 1'b0);
    drive(1'b1, W'(3), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Backpressure then drain in order.
    a = rnd();
    b = rnd();
    drive(1'b1, a, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Stall hold: FULL with toggling input data that must not be accepted.
    drive(1'b1, a, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, ~in_data, 1'b0, 1'b0);

    // Flush with a coincident input that must never appear.
    drive(1'b1, rnd(), 1'b0, 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset while FULL, between clock edges.
    drive(1'b1, a, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", W'(count_w), '0);
    chk("arst_in_ready", W'(in_ready_w), W'(1));
    chk("arst_out_valid", W'(out_valid_w), '0);
    chk("arst_w_data", out_data_w, '0);
    chk("arst_n_data", W'(out_data_n), W'(1));
    exp_q.delete();
    reset = 1'b1;
    drive(1'b1, rnd(), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0));
    end
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
